// File: rtl/ps2_rx_if.sv
// Key-event bus of the PS/2 receiver: raw pin inputs plus decoded key outputs.
// The receiver uses the master side; the consumer/pin driver uses the slave side.
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key;
  logic       key_released;
  logic       extended;
  logic       done;
  logic       frame_err;

  modport master (
    input  ps2_clk, ps2_data,
    output key, key_released, extended, done, frame_err
  );

  modport slave (
    output ps2_clk, ps2_data,
    input  key, key_released, extended, done, frame_err
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: synchronises the pins, frames 11-bit bytes and folds
// E0/F0 prefixes into one key event per make/break code.
module ps2_rx #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic     clk,
  input  logic     rst,
  ps2_rx_if.master bus
);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          c0_q, c1_q, c2_q, d0_q, d1_q;
  logic          c0_d, c1_d, c2_d, d0_d, d1_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d, stop_q, stop_d;
  logic          brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    key_q, key_d;
  logic          key_released_q, key_released_d;
  logic          extended_q, extended_d;
  logic          done_q, done_d;
  logic          frame_err_q, frame_err_d;
  logic          fall;

  function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

  assign fall = c2_q & ~c1_q;

  // Next-state logic for synchroniser, framing FSM, prefix tracking and outputs.
  always_comb begin
    state_d        = state_q;
    c0_d           = bus.ps2_clk;
    c1_d           = c0_q;
    c2_d           = c1_q;
    d0_d           = bus.ps2_data;
    d1_d           = d0_q;
    bitcnt_d       = bitcnt_q;
    shreg_d        = shreg_q;
    par_d          = par_q;
    stop_d         = stop_q;
    brk_pend_d     = brk_pend_q;
    ext_pend_d     = ext_pend_q;
    tmo_d          = tmo_q;
    key_d          = key_q;
    key_released_d = key_released_q;
    extended_d     = extended_q;
    done_d         = 1'b0;
    frame_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (fall && !d1_q) begin
          state_d  = RECV;
          bitcnt_d = 4'd1;
        end else begin
          bitcnt_d = 4'd0;
        end
      end
      RECV: begin
        // Timeout takes priority over a fall arriving in the same cycle.
        if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          bitcnt_d    = 4'd0;
          tmo_d       = '0;
          frame_err_d = 1'b1;
          brk_pend_d  = 1'b0;
          ext_pend_d  = 1'b0;
        end else if (fall) begin
          tmo_d    = '0;
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q <= 4'd8) begin
            shreg_d = {d1_q, shreg_q[7:1]};
          end else if (bitcnt_q == 4'd9) begin
            par_d = d1_q;
          end else begin
            stop_d   = d1_q;
            state_d  = CHECK;
            bitcnt_d = 4'd0;
          end
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        tmo_d   = '0;
        if (!odd_parity_ok(shreg_q, par_q) || !stop_q) begin
          frame_err_d = 1'b1;
          brk_pend_d  = 1'b0;
          ext_pend_d  = 1'b0;
        end else if (shreg_q == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else if (shreg_q == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else begin
          key_d          = shreg_q;
          key_released_d = brk_pend_q;
          extended_d     = ext_pend_q;
          done_d         = 1'b1;
          brk_pend_d     = 1'b0;
          ext_pend_d     = 1'b0;
        end
      end
      default: begin
        state_d  = IDLE;
        bitcnt_d = 4'd0;
        tmo_d    = '0;
      end
    endcase
  end

  // State and output registers; synchroniser flops reset to the idle-high bus level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      c0_q           <= 1'b1;
      c1_q           <= 1'b1;
      c2_q           <= 1'b1;
      d0_q           <= 1'b1;
      d1_q           <= 1'b1;
      bitcnt_q       <= 4'd0;
      shreg_q        <= 8'h00;
      par_q          <= 1'b0;
      stop_q         <= 1'b0;
      brk_pend_q     <= 1'b0;
      ext_pend_q     <= 1'b0;
      tmo_q          <= '0;
      key_q          <= 8'h00;
      key_released_q <= 1'b0;
      extended_q     <= 1'b0;
      done_q         <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      c0_q           <= c0_d;
      c1_q           <= c1_d;
      c2_q           <= c2_d;
      d0_q           <= d0_d;
      d1_q           <= d1_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      par_q          <= par_d;
      stop_q         <= stop_d;
      brk_pend_q     <= brk_pend_d;
      ext_pend_q     <= ext_pend_d;
      tmo_q          <= tmo_d;
      key_q          <= key_d;
      key_released_q <= key_released_d;
      extended_q     <= extended_d;
      done_q         <= done_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign bus.key          = key_q;
  assign bus.key_released = key_released_q;
  assign bus.extended     = extended_q;
  assign bus.done         = done_q;
  assign bus.frame_err    = frame_err_q;
endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: hand-built PS/2 frames with expected key events,
// using a shortened PS/2 bit period and TIMEOUT so the run stays short.
module tb_ps2_rx;
  localparam int TMO  = 500;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  ps2_rx_if bus();

  ps2_rx #(.TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int both_cnt = 0;
  int done_cyc = 0;
  int last_fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (bus.frame_err) ferr_cnt <= ferr_cnt + 1;
    if (bus.done && bus.frame_err) both_cnt <= both_cnt + 1;
  end

  function automatic logic [10:0] build(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f[0]   = 1'b0;
    f[8:1] = b;
    f[9]   = (~^b) ^ bad_par;
    f[10]  = ~bad_stop;
    return f;
  endfunction

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    bus.ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    bus.ps2_clk   = 1'b0;
    last_fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = build(b, bad_par, bad_stop);
    for (int i = 0; i < 11; i++) ps2_bit(f[i]);
    bus.ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.key !== 8'h00) begin errors++; $display("FAIL reset_key: got %h expected %h", bus.key, 8'h00); end
    checks++; if (bus.key_released !== 1'b0) begin errors++; $display("FAIL reset_released: got %b expected 0", bus.key_released); end
    checks++; if (bus.extended !== 1'b0) begin errors++; $display("FAIL reset_extended: got %b expected 0", bus.extended); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
  endtask

  task automatic test_make();
    int d0, e0;
    d0 = done_cnt; e0 = ferr_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL make_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL make_err_count: got %0d expected 0", ferr_cnt - e0); end
    checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL make_key: got %h expected 1c", bus.key); end
    checks++; if (bus.key_released !== 1'b0) begin errors++; $display("FAIL make_released: got %b expected 0", bus.key_released); end
    checks++; if (bus.extended !== 1'b0) begin errors++; $display("FAIL make_extended: got %b expected 0", bus.extended); end
    checks++; if (done_cyc - last_fall_cyc !== 4) begin errors++; $display("FAIL make_latency: got %0d expected 4", done_cyc - last_fall_cyc); end
  endtask

  task automatic test_break();
    int d0;
    d0 = done_cnt;
    send_frame(8'hF0, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL break_prefix_done: got %0d expected 0", done_cnt - d0); end
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL break_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL break_key: got %h expected 1c", bus.key); end
    checks++; if (bus.key_released !== 1'b1) begin errors++; $display("FAIL break_released: got %b expected 1", bus.key_released); end
    checks++; if (bus.extended !== 1'b0) begin errors++; $display("FAIL break_extended: got %b expected 0", bus.extended); end
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (bus.key_released !== 1'b0) begin errors++; $display("FAIL break_then_make_released: got %b expected 0", bus.key_released); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL break_then_make_done: got %0d expected 2", done_cnt - d0); end
  endtask

  task automatic test_extended();
    int d0;
    d0 = done_cnt;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h6B, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ext_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (bus.key !== 8'h6B) begin errors++; $display("FAIL ext_key: got %h expected 6b", bus.key); end
    checks++; if (bus.extended !== 1'b1) begin errors++; $display("FAIL ext_extended: got %b expected 1", bus.extended); end
    checks++; if (bus.key_released !== 1'b0) begin errors++; $display("FAIL ext_released: got %b expected 0", bus.key_released); end
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h74, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL ext_brk_done_count: got %0d expected 2", done_cnt - d0); end
    checks++; if (bus.key !== 8'h74) begin errors++; $display("FAIL ext_brk_key: got %h expected 74", bus.key); end
    checks++; if (bus.extended !== 1'b1) begin errors++; $display("FAIL ext_brk_extended: got %b expected 1", bus.extended); end
    checks++; if (bus.key_released !== 1'b1) begin errors++; $display("FAIL ext_brk_released: got %b expected 1", bus.key_released); end
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL brk_ext_done_count: got %0d expected 3", done_cnt - d0); end
    checks++; if (bus.key !== 8'h75) begin errors++; $display("FAIL brk_ext_key: got %h expected 75", bus.key); end
    checks++; if ({bus.extended, bus.key_released} !== 2'b11) begin errors++; $display("FAIL brk_ext_flags: got %b expected 11", {bus.extended, bus.key_released}); end
  endtask

  task automatic test_errors();
    int d0, e0;
    d0 = done_cnt; e0 = ferr_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    checks++; if (ferr_cnt - e0 !== 1) begin errors++; $display("FAIL parity_err_count: got %0d expected 1", ferr_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL parity_done_count: got %0d expected 0", done_cnt - d0); end
    checks++; if (bus.key !== 8'h75) begin errors++; $display("FAIL parity_key_held: got %h expected 75", bus.key); end
    send_frame(8'h1C, 1'b0, 1'b1);
    checks++; if (ferr_cnt - e0 !== 2) begin errors++; $display("FAIL stop_err_count: got %0d expected 2", ferr_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL stop_done_count: got %0d expected 0", done_cnt - d0); end
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (ferr_cnt - e0 !== 3) begin errors++; $display("FAIL pend_err_count: got %0d expected 3", ferr_cnt - e0); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL pend_done_count: got %0d expected 1", done_cnt - d0); end
    checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL pend_key: got %h expected 1c", bus.key); end
    checks++; if (bus.key_released !== 1'b0) begin errors++; $display("FAIL pend_released_cleared: got %b expected 0", bus.key_released); end
  endtask

  task automatic test_timeout();
    int d0, e0;
    logic [10:0] f;
    send_frame(8'h5A, 1'b0, 1'b0);
    d0 = done_cnt; e0 = ferr_cnt;
    f = build(8'h1C, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(f[i]);
    repeat (TMO - 90) @(negedge clk);
    checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL timeout_early: got %0d expected 0", ferr_cnt - e0); end
    repeat (120) @(negedge clk);
    checks++; if (ferr_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err_count: got %0d expected 1", ferr_cnt - e0); end
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL timeout_done_count: got %0d expected 0", done_cnt - d0); end
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL timeout_next_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL timeout_next_key: got %h expected 1c", bus.key); end
    checks++; if (ferr_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_next_err: got %0d expected 1", ferr_cnt - e0); end
  endtask

  task automatic test_reset_mid();
    int d0, e0;
    logic [10:0] f;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b0);
    d0 = done_cnt; e0 = ferr_cnt;
    // C3 keeps the tail bits (data6, data7, parity, stop) all high so none look like a start bit.
    f = build(8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) ps2_bit(f[i]);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++; if (bus.key !== 8'h00) begin errors++; $display("FAIL rstmid_key: got %h expected 00", bus.key); end
    checks++; if ({bus.extended, bus.key_released} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: got %b expected 00", {bus.extended, bus.key_released}); end
    for (int i = 7; i < 11; i++) ps2_bit(f[i]);
    repeat (20) @(negedge clk);
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt - d0); end
    checks++; if (ferr_cnt - e0 !== 0) begin errors++; $display("FAIL rstmid_no_err: got %0d expected 0", ferr_cnt - e0); end
    send_frame(8'h1C, 1'b0, 1'b0);
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rstmid_next_done: got %0d expected 1", done_cnt - d0); end
    checks++; if (bus.key !== 8'h1C) begin errors++; $display("FAIL rstmid_next_key: got %h expected 1c", bus.key); end
    checks++; if ({bus.extended, bus.key_released} !== 2'b00) begin errors++; $display("FAIL rstmid_next_flags: got %b expected 00", {bus.extended, bus.key_released}); end
  endtask

  task automatic test_exclusive();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL done_err_overlap: got %0d expected 0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
